sense_filter_bank: RTL and testbench
====================================

SENSE_FILTER_BANK -- requirements
Module: sense_filter_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent sense channels.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 16, width of rate counters and limits.
REQ-003 SHALL have parameter STRIKE_WIDTH, default 4, width of consecutive-violation counters and threshold.
REQ-004 SHALL have port sys_clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port sync_rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable_i  input  1  bank enable.
REQ-007 SHALL have port sense_i  input  CHANNELS  raw sense level per channel, synchronous to sys_clk_i.
REQ-008 SHALL have port polarity_en_i  input  CHANNELS  per-channel polarity filtering enable.
REQ-009 SHALL have port polarity_i  input  CHANNELS  0 = track high phase, 1 = track low phase.
REQ-010 SHALL have ports min_band_m1_i, min_violation_m1_i, max_violation_m1_i, max_band_m1_i  input  COUNTER_WIDTH each  shared limits (minus one).
REQ-011 SHALL have port strike_limit_i  input  STRIKE_WIDTH  consecutive violations to raise a fault; 0 disables faults.
REQ-012 SHALL have port fault_clear_i  input  CHANNELS  per-channel sticky fault clear.
REQ-013 SHALL have outputs event_o, over_violation_o, under_violation_o, over_fault_o, under_fault_o  CHANNELS each.
REQ-014 SHALL have output rate_o  CHANNELS*COUNTER_WIDTH  last accepted interval per channel, channel n at bits [n*COUNTER_WIDTH +: COUNTER_WIDTH].

Function
REQ-015 Per channel, sense_q SHALL register sense_i; an edge exists when sense_i != sense_q (rise: sense_i=1; fall: sense_i=0).
REQ-016 Rate counter SHALL increment by 1 per cycle, saturating at all-ones; on restart it loads 0, so an edge N cycles after the previous restart sees count N-1.
REQ-017 Edge classification uses current count C: under-band if C <= min_band_m1_i; over-band if C >= max_band_m1_i; otherwise in-band.
REQ-018 Under-band edge: ignored (glitch), no restart, no output, no strike change.
REQ-019 Over-band edge: ignored for output/violations, counter restarts (resync), strike counters unchanged.
REQ-020 In-band edge: counter restarts; edge is accepted.
REQ-021 Unarmed channel (after reset/disable): first edge of any class only restarts counter and sets armed; no outputs.
REQ-022 Polarity qualification of accepted edge: polarity_en_i=0 -> both edges qualify; polarity_en_i=1, polarity_i=0 -> falling edges only; polarity_i=1 -> rising edges only. Restart on unqualified accepted edges still occurs.
REQ-023 Qualified edge SHALL, registered, one cycle later: pulse event_o for 1 cycle and load C into rate_o (held until next qualified edge).
REQ-024 Qualified edge with C >= max_violation_m1_i SHALL pulse over_violation_o; with C <= min_violation_m1_i SHALL pulse under_violation_o (same cycle as event_o); both may not assert together unless limits overlap, in which case both pulse.
REQ-025 Separate over/under strike counters: increment (saturating) on own violation; clear on a qualified non-violating edge; opposite-direction violation clears the other counter.
REQ-026 When strike_limit_i != 0 and a strike counter reaches strike_limit_i, corresponding fault output SHALL set the following cycle and stay set.
REQ-027 fault_clear_i[n] SHALL clear both faults and strike counters of channel n next cycle; clear wins over simultaneous set.
REQ-028 enable_i=0 SHALL clear counters, strikes, armed, and pulse outputs; sense_q keeps tracking; rate_o and faults hold.
REQ-029 Channels SHALL be fully independent; no cross-channel combinational paths; all outputs registered.

Reset
REQ-030 On sync_rst_i=1 all counters, strikes, sense_q, armed, rate_o and every output SHALL be 0 the next cycle; reset overrides enable_i and fault_clear_i.
REQ-031 Reset asserted mid-interval SHALL discard the interval; first post-reset edge only arms (REQ-021).

Verification
REQ-032 Limits 2/4/20/30, polarity_en=0, square wave period 20 (10-cycle phases) -> event_o each edge, rate_o=9, no violations.
REQ-033 Same limits, one 2-cycle glitch inside a high phase -> glitch edges ignored, rate_o stays 9, counter unbroken.
REQ-034 polarity_en=1, polarity=1, high 10/low 24 cycles -> events on rising edges only, rate_o=23, over_violation_o pulses each event; strike_limit=3 -> over_fault_o sets after 3rd violation.
REQ-035 Fault set, fault_clear_i pulsed in same cycle as 4th violation -> fault low next cycle, strike=0, fault resets after 3 further violations.
REQ-036 sync_rst_i asserted mid-phase, then 10-cycle phases -> first edge produces no event_o; second edge event_o with rate_o=9.

Source files
------------

// File: rtl/sense_filter_bank.sv
// Bank of independent edge-rate filters: each channel times the interval between
// accepted sense edges, rejects glitches/overlong gaps, and flags rate violations and faults.
module sense_filter_bank #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int STRIKE_WIDTH  = 4
) (
    input  logic                              sys_clk_i,
    input  logic                              sync_rst_i,
    input  logic                              enable_i,
    input  logic [CHANNELS-1:0]               sense_i,
    input  logic [CHANNELS-1:0]               polarity_en_i,
    input  logic [CHANNELS-1:0]               polarity_i,
    input  logic [COUNTER_WIDTH-1:0]          min_band_m1_i,
    input  logic [COUNTER_WIDTH-1:0]          min_violation_m1_i,
    input  logic [COUNTER_WIDTH-1:0]          max_violation_m1_i,
    input  logic [COUNTER_WIDTH-1:0]          max_band_m1_i,
    input  logic [STRIKE_WIDTH-1:0]           strike_limit_i,
    input  logic [CHANNELS-1:0]               fault_clear_i,
    output logic [CHANNELS-1:0]               event_o,
    output logic [CHANNELS-1:0]               over_violation_o,
    output logic [CHANNELS-1:0]               under_violation_o,
    output logic [CHANNELS-1:0]               over_fault_o,
    output logic [CHANNELS-1:0]               under_fault_o,
    output logic [CHANNELS*COUNTER_WIDTH-1:0] rate_o
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(1);
    localparam logic [STRIKE_WIDTH-1:0]  STRIKE_ONE = STRIKE_WIDTH'(1);

    genvar n;
    for (n = 0; n < CHANNELS; n++) begin : g_ch
        logic                     sense_q;
        logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
        logic                     armed_q, armed_d;
        logic [STRIKE_WIDTH-1:0]  over_strike_q, over_strike_d;
        logic [STRIKE_WIDTH-1:0]  under_strike_q, under_strike_d;
        logic                     event_q, event_d;
        logic                     over_viol_q, over_viol_d;
        logic                     under_viol_q, under_viol_d;
        logic                     over_fault_q, over_fault_d;
        logic                     under_fault_q, under_fault_d;
        logic [COUNTER_WIDTH-1:0] rate_q, rate_d;

        logic                     is_edge;
        logic                     under_band;
        logic                     over_band;
        logic                     qualified;
        logic [COUNTER_WIDTH-1:0] cnt_inc;
        logic [STRIKE_WIDTH-1:0]  over_strike_inc;
        logic [STRIKE_WIDTH-1:0]  under_strike_inc;

        assign is_edge    = sense_i[n] ^ sense_q;
        assign under_band = (cnt_q <= min_band_m1_i);
        assign over_band  = (cnt_q >= max_band_m1_i);
        // polarity=0 tracks the high phase, so the falling edge closes the interval
        assign qualified  = !polarity_en_i[n] || (polarity_i[n] ? sense_i[n] : !sense_i[n]);

        assign cnt_inc          = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        assign over_strike_inc  = (&over_strike_q) ? over_strike_q : over_strike_q + STRIKE_ONE;
        assign under_strike_inc = (&under_strike_q) ? under_strike_q : under_strike_q + STRIKE_ONE;

        always_comb begin
            cnt_d          = cnt_inc;
            armed_d        = armed_q;
            over_strike_d  = over_strike_q;
            under_strike_d = under_strike_q;
            event_d        = 1'b0;
            over_viol_d    = 1'b0;
            under_viol_d   = 1'b0;
            rate_d         = rate_q;
            over_fault_d   = over_fault_q;
            under_fault_d  = under_fault_q;

            if (!enable_i) begin
                cnt_d          = '0;
                armed_d        = 1'b0;
                over_strike_d  = '0;
                under_strike_d = '0;
            end else if (is_edge) begin
                if (!armed_q) begin
                    armed_d = 1'b1;
                    cnt_d   = '0;
                end else if (!under_band) begin
                    // over-band edges only resync the counter
                    cnt_d = '0;
                    if (!over_band && qualified) begin
                        event_d        = 1'b1;
                        rate_d         = cnt_q;
                        over_viol_d    = (cnt_q >= max_violation_m1_i);
                        under_viol_d   = (cnt_q <= min_violation_m1_i);
                        over_strike_d  = over_viol_d ? over_strike_inc : '0;
                        under_strike_d = under_viol_d ? under_strike_inc : '0;
                    end
                end
            end

            if (fault_clear_i[n]) begin
                over_strike_d  = '0;
                under_strike_d = '0;
                over_fault_d   = 1'b0;
                under_fault_d  = 1'b0;
            end else begin
                if (strike_limit_i != '0 && over_strike_d >= strike_limit_i)
                    over_fault_d = 1'b1;
                if (strike_limit_i != '0 && under_strike_d >= strike_limit_i)
                    under_fault_d = 1'b1;
            end
        end

        always_ff @(posedge sys_clk_i) begin
            if (sync_rst_i) begin
                sense_q        <= 1'b0;
                cnt_q          <= '0;
                armed_q        <= 1'b0;
                over_strike_q  <= '0;
                under_strike_q <= '0;
                event_q        <= 1'b0;
                over_viol_q    <= 1'b0;
                under_viol_q   <= 1'b0;
                over_fault_q   <= 1'b0;
                under_fault_q  <= 1'b0;
                rate_q         <= '0;
            end else begin
                sense_q        <= sense_i[n];
                cnt_q          <= cnt_d;
                armed_q        <= armed_d;
                over_strike_q  <= over_strike_d;
                under_strike_q <= under_strike_d;
                event_q        <= event_d;
                over_viol_q    <= over_viol_d;
                under_viol_q   <= under_viol_d;
                over_fault_q   <= over_fault_d;
                under_fault_q  <= under_fault_d;
                rate_q         <= rate_d;
            end
        end

        assign event_o[n]                                  = event_q;
        assign over_violation_o[n]                         = over_viol_q;
        assign under_violation_o[n]                        = under_viol_q;
        assign over_fault_o[n]                             = over_fault_q;
        assign under_fault_o[n]                            = under_fault_q;
        assign rate_o[n*COUNTER_WIDTH +: COUNTER_WIDTH]    = rate_q;
    end

endmodule

// File: tb/tb_sense_filter_bank.sv
// Bench for sense_filter_bank: directed scenarios then randomized phases, every cycle
// compared against an interval-timestamp reference model.
module tb_sense_filter_bank;

    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int SW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           en;
    logic [CH-1:0]  sense, pe, pol, fclr;
    logic [CW-1:0]  minb, minv, maxv, maxb;
    logic [SW-1:0]  slim;
    logic [CH-1:0]  event_o, over_violation_o, under_violation_o, over_fault_o, under_fault_o;
    logic [CH*CW-1:0] rate_o;

    sense_filter_bank #(.CHANNELS(CH), .COUNTER_WIDTH(CW), .STRIKE_WIDTH(SW)) dut (
        .sys_clk_i          (clk),
        .sync_rst_i         (rst),
        .enable_i           (en),
        .sense_i            (sense),
        .polarity_en_i      (pe),
        .polarity_i         (pol),
        .min_band_m1_i      (minb),
        .min_violation_m1_i (minv),
        .max_violation_m1_i (maxv),
        .max_band_m1_i      (maxb),
        .strike_limit_i     (slim),
        .fault_clear_i      (fclr),
        .event_o            (event_o),
        .over_violation_o   (over_violation_o),
        .under_violation_o  (under_violation_o),
        .over_fault_o       (over_fault_o),
        .under_fault_o      (under_fault_o),
        .rate_o             (rate_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: interval measured as cycles since the last restart timestamp
    int m_rs[CH];
    bit m_sq[CH], m_arm[CH], m_ev[CH], m_ov[CH], m_uv[CH], m_of[CH], m_uf[CH];
    int m_os[CH], m_us[CH], m_rate[CH];

    // phase generator state
    int hi_len[CH], lo_len[CH], cur_len[CH], ph_cnt[CH];
    bit ph_lvl[CH], glitch_en[CH];
    bit rnd_len = 1'b0;
    logic [CH-1:0] seen_ev, seen_ov, seen_uv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int cur_c(input int ch);
        int c;
        c = cyc - m_rs[ch] - 1;
        return (c > CMAX) ? CMAX : c;
    endfunction

    function automatic bit qual(input int ch);
        return !pe[ch] || (pol[ch] ? sense[ch] : !sense[ch]);
    endfunction

    function automatic bit pred_viol0();
        int c;
        c = cur_c(0);
        return !rst && en && (sense[0] != m_sq[0]) && m_arm[0] && (c > int'(minb)) &&
               (c < int'(maxb)) && qual(0) && (c >= int'(maxv));
    endfunction

    task automatic model_step();
        for (int ch = 0; ch < CH; ch++) begin
            m_ev[ch] = 0; m_ov[ch] = 0; m_uv[ch] = 0;
            if (rst) begin
                m_rs[ch] = cyc; m_sq[ch] = 0; m_arm[ch] = 0; m_os[ch] = 0; m_us[ch] = 0;
                m_of[ch] = 0; m_uf[ch] = 0; m_rate[ch] = 0;
            end else begin
                int c;
                bit edge_seen;
                c = cur_c(ch);
                edge_seen = (sense[ch] != m_sq[ch]);
                m_sq[ch] = sense[ch];
                if (!en) begin
                    m_rs[ch] = cyc; m_arm[ch] = 0; m_os[ch] = 0; m_us[ch] = 0;
                end else if (edge_seen) begin
                    if (!m_arm[ch]) begin
                        m_arm[ch] = 1; m_rs[ch] = cyc;
                    end else if (c > int'(minb)) begin
                        m_rs[ch] = cyc;
                        if (c < int'(maxb) && qual(ch)) begin
                            m_ev[ch]   = 1;
                            m_rate[ch] = c;
                            m_ov[ch]   = (c >= int'(maxv));
                            m_uv[ch]   = (c <= int'(minv));
                            m_os[ch]   = m_ov[ch] ? ((m_os[ch] + 1 > 15) ? 15 : m_os[ch] + 1) : 0;
                            m_us[ch]   = m_uv[ch] ? ((m_us[ch] + 1 > 15) ? 15 : m_us[ch] + 1) : 0;
                        end
                    end
                end
                if (fclr[ch]) begin
                    m_os[ch] = 0; m_us[ch] = 0; m_of[ch] = 0; m_uf[ch] = 0;
                end else begin
                    if (slim != 0 && m_os[ch] >= int'(slim)) m_of[ch] = 1;
                    if (slim != 0 && m_us[ch] >= int'(slim)) m_uf[ch] = 1;
                end
            end
        end
    endtask

    // scoreboard: one comparison per channel per cycle
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int ch = 0; ch < CH; ch++) begin
            logic [20:0] got, exp;
            got = {event_o[ch], over_violation_o[ch], under_violation_o[ch],
                   over_fault_o[ch], under_fault_o[ch], rate_o[ch*CW +: CW]};
            exp = {m_ev[ch], m_ov[ch], m_uv[ch], m_of[ch], m_uf[ch], 16'(m_rate[ch])};
            chk($sformatf("cyc%0d_ch%0d", cyc, ch), 64'(got), 64'(exp));
        end
        seen_ev |= event_o;
        seen_ov |= over_violation_o;
        seen_uv |= under_violation_o;
        cyc++;
    endtask

    // driver: square wave per channel, optional early glitch in high phase
    task automatic drive();
        for (int ch = 0; ch < CH; ch++) begin
            int pos;
            if (ph_cnt[ch] == 0) begin
                ph_lvl[ch]  = !ph_lvl[ch];
                cur_len[ch] = rnd_len ? int'($urandom_range(1, 45)) : (ph_lvl[ch] ? hi_len[ch] : lo_len[ch]);
                ph_cnt[ch]  = cur_len[ch];
            end
            pos = cur_len[ch] - ph_cnt[ch];
            sense[ch] = ph_lvl[ch] ^ (glitch_en[ch] && ph_lvl[ch] && (pos == 1 || pos == 2));
            ph_cnt[ch]--;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic set_phases(input int hi, input int lo);
        for (int ch = 0; ch < CH; ch++) begin
            hi_len[ch] = hi;
            lo_len[ch] = lo;
        end
    endtask

    initial begin
        bit found;
        int nv;
        rst = 1; en = 0; sense = '0; pe = '0; pol = '0; fclr = '0;
        minb = 16'd2; minv = 16'd4; maxv = 16'd20; maxb = 16'd30; slim = 4'd3;
        for (int ch = 0; ch < CH; ch++) begin
            m_rs[ch] = -1; m_sq[ch] = 0; m_arm[ch] = 0; m_os[ch] = 0; m_us[ch] = 0;
            m_of[ch] = 0; m_uf[ch] = 0; m_rate[ch] = 0;
            ph_cnt[ch] = 0; ph_lvl[ch] = 1; glitch_en[ch] = 0;
        end
        set_phases(10, 10);

        // reset state
        repeat (3) tick();
        chk("reset_event", 64'(event_o), 64'(0));
        chk("reset_faults", 64'({over_fault_o, under_fault_o}), 64'(0));
        chk("reset_rate", 64'(rate_o), 64'(0));

        // 10-cycle phases, both edges accepted
        rst = 0; en = 1;
        seen_ev = '0; seen_ov = '0; seen_uv = '0;
        run(120);
        chk("sq_rate", 64'(rate_o[CW-1:0]), 64'(9));
        chk("sq_events_all_ch", 64'(seen_ev), 64'(4'hF));
        chk("sq_no_viol", 64'(seen_ov | seen_uv), 64'(0));

        // short glitch early in a high phase on channel 0
        seen_ov = '0; seen_uv = '0;
        glitch_en[0] = 1;
        run(40);
        glitch_en[0] = 0;
        run(20);
        chk("glitch_rate", 64'(rate_o[CW-1:0]), 64'(9));
        chk("glitch_no_viol", 64'(seen_ov | seen_uv), 64'(0));

        // disable window then resume
        en = 0;
        run(7);
        en = 1;
        run(40);

        // rising-edge-only, long low phase: over violations build a fault
        pe = '1; pol = '1;
        set_phases(10, 24);
        seen_uv = '0;
        run(200);
        chk("pol_rate", 64'(rate_o[CW-1:0]), 64'(23));
        chk("pol_over_fault", 64'(over_fault_o), 64'(4'hF));
        chk("pol_no_under", 64'(seen_uv), 64'(0));

        // clear coincident with a violation wins, fault returns after 3 more
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            drive();
            if (pred_viol0()) begin
                fclr[0] = 1;
                found = 1;
            end
            tick();
            fclr[0] = 0;
        end
        chk("clr_found", 64'(found), 64'(1));
        chk("clr_fault_low", 64'(over_fault_o[0]), 64'(0));
        chk("clr_other_ch_kept", 64'(over_fault_o[3:1]), 64'(3'h7));
        nv = 0;
        for (int i = 0; i < 200 && nv < 3; i++) begin
            drive();
            tick();
            if (over_violation_o[0]) begin
                nv++;
                if (nv == 2) chk("clr_fault_after2", 64'(over_fault_o[0]), 64'(0));
            end
        end
        chk("clr_viol_count", 64'(nv), 64'(3));
        chk("clr_fault_reset", 64'(over_fault_o[0]), 64'(1));

        // reset mid low phase: first edge arms only, second reports 9
        pe = '0; pol = '0;
        set_phases(10, 10);
        run(60);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            drive();
            if (sense[0] == 0 && ph_cnt[0] == 5) begin
                rst = 1;
                found = 1;
            end
            tick();
            rst = 0;
        end
        chk("rst_mid_found", 64'(found), 64'(1));
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            drive();
            tick();
            if (event_o[0]) begin
                found = 1;
                chk("rst_first_event_rate", 64'(rate_o[CW-1:0]), 64'(9));
            end
        end
        chk("rst_event_seen", 64'(found), 64'(1));

        // randomized phases and configuration
        rnd_len = 1;
        for (int blk = 0; blk < 6; blk++) begin
            minb = 16'($urandom_range(0, 5));
            minv = minb + 16'($urandom_range(0, 6));
            maxv = 16'($urandom_range(12, 30));
            maxb = maxv + 16'($urandom_range(0, 12));
            slim = 4'($urandom_range(0, 5));
            pe   = 4'($urandom());
            pol  = 4'($urandom());
            repeat (500) begin
                for (int ch = 0; ch < CH; ch++) fclr[ch] = ($urandom_range(0, 63) == 0);
                en  = ($urandom_range(0, 199) != 0);
                rst = ($urandom_range(0, 999) == 0);
                drive();
                tick();
                fclr = '0;
                rst  = 0;
            end
            en = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
